inst_cache_refill: RTL and testbench
====================================

Name: inst_cache_refill

Overview:
- Fill engine on the write side of the 128-word instruction cache.
- On a fetch miss it bursts one aligned line of instruction words from main memory over a valid/ready request channel and an in-order response channel.
- It writes each returned word into the cache through the cache write port (WriteInst / CacheIndexWrite / InstData), then signals completion to the fetch stage.

Parameters:
- LINE_WORDS, 4, words per refill line; power of two, 2..16.
- INDEX_W, 7, cache word-index width; cache depth = 2**INDEX_W.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  system clock
- Reset  input  1  reset; one clock, reset is synchronous and active-high
- MissReq  input  1  refill request; sampled only in IDLE
- MissAddr  input  ADDR_W  byte address of the missing instruction
- RefillBusy  output  1  high from the cycle after acceptance until Done
- RefillDone  output  1  one-cycle pulse after the last cache write
- MemReqValid  output  1  memory read request valid
- MemReqReady  input  1  memory accepts the request this cycle
- MemReqAddr  output  ADDR_W  word-aligned read byte address (bits[1:0]=0)
- MemRespValid  input  1  read data valid; responses return in request order
- MemRespData  input  32  read data
- WriteInst  output  1  cache write strobe
- CacheIndexWrite  output  INDEX_W  cache word index
- InstData  output  32  cache write data

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, all counters 0.
- Reset asserted mid-refill aborts it immediately: no Done pulse, no further writes.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - MissReq=1 latches MissAddr.
  - Line base byte address = MissAddr with bits[log2(LINE_WORDS)+1:0] cleared.
  - Next state ISSUE; RefillBusy=1 from the next cycle.
  - MemRespValid in IDLE is ignored; no write occurs.
- ISSUE:
  - MemReqValid=1, MemReqAddr = current request address.
  - MemReqAddr/MemReqValid must stay stable while Valid=1 and Ready=0.
  - On Valid&Ready: request count +1 and address advances one word (+4).
  - After LINE_WORDS handshakes go to DRAIN, or directly to DONE if all responses are already written.
  - Back-to-back handshakes are allowed, one per cycle.
- Responses may arrive while in ISSUE, from the cycle after the first accepted request.
  - Each MemRespValid produces a registered write: WriteInst=1 on the next cycle.
  - InstData = MemRespData.
  - CacheIndexWrite = word index (byte address bits[INDEX_W+1:2]) of the matching request, tracked by a separate response counter.
  - Write latency is exactly 1 cycle, up to one write per cycle.
- DRAIN: MemReqValid=0; wait until LINE_WORDS writes have been issued.
- DONE:
  - RefillDone=1 for exactly one cycle, in the cycle after the final WriteInst.
  - RefillBusy=0 in that same cycle.
  - Return to IDLE; a new MissReq is accepted in the following cycle.
- MissReq while not IDLE is ignored. The requester holds it until RefillDone if it still needs the line.
- Index wrap: line base plus offset wraps modulo 2**INDEX_W for the cache index. MemReqAddr does not wrap the line; it stays inside the aligned line.
- MemRespValid beyond LINE_WORDS responses in one refill is a protocol error: ignored, no write.
- Counters are log2(LINE_WORDS)+1 bits wide; no overflow is permitted.

Optional Feature:
- Macro: INST_REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Requests start at the missed word (MissAddr word offset) and wrap modulo LINE_WORDS within the aligned line.
  - Cache writes follow the same order.
  - Adds output CritWordWritten, a 1-cycle pulse coincident with the first WriteInst, so fetch may restart early.
- Undefined: requests start at line word 0 in ascending order, and the CritWordWritten port is absent.

Test Plan:
- Basic refill, no back-pressure:
  - Stimulus: MissAddr=0x0000_0124, Ready=1, responses 0xA0..0xA3 one cycle after each request.
  - Required: MemReqAddr 0x120, 0x124, 0x128, 0x12C; writes to index 0x48..0x4B with 0xA0..0xA3; RefillDone one cycle after the last write; RefillBusy low the same cycle.
- Back-pressure:
  - Stimulus: Ready toggles 0,1,0,0,1,...
  - Required: MemReqAddr/Valid stable across stalls, exactly 4 handshakes, data and indices as in the basic refill.
- Index wrap:
  - Stimulus: MissAddr=0x0000_01F8.
  - Required: writes to indices 0x7C..0x7F. With INDEX_W=7 and MissAddr=0x0000_03F0, indices are 0x7C..0x7F (bit 9 dropped).
- Reset mid-refill:
  - Stimulus: assert Reset after 2 writes, then deliver 2 late responses.
  - Required: all outputs 0 the cycle after Reset; late responses produce no WriteInst and no RefillDone.
- MissReq while busy:
  - Stimulus: a second MissReq during DRAIN.
  - Required: ignored; accepted only in the cycle after RefillDone when still held.
- Critical word first (macro defined):
  - Stimulus: MissAddr=0x128.
  - Required: request order 0x128, 0x12C, 0x120, 0x124; CritWordWritten coincides with the index 0x4A write.

Source files
------------

// File: rtl/inst_cache_refill.sv
// inst_cache_refill: instruction-cache line refill engine (memory burst read, cache write, done pulse).
// Define INST_REFILL_CRITICAL_WORD_FIRST_EN to start at the missed word and add CritWordWritten.
module inst_cache_refill #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W = 7,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic Reset,
  input  logic MissReq,
  input  logic [ADDR_W-1:0] MissAddr,
  output logic RefillBusy,
  output logic RefillDone,
  output logic MemReqValid,
  input  logic MemReqReady,
  output logic [ADDR_W-1:0] MemReqAddr,
  input  logic MemRespValid,
  input  logic [31:0] MemRespData,
  output logic WriteInst,
  output logic [INDEX_W-1:0] CacheIndexWrite,
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
  output logic CritWordWritten,
`endif
  output logic [31:0] InstData
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_WORDS);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0] start_q, start_d, req_off, resp_off;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
  logic hs, resp_ok, wr_q;
  logic [INDEX_W-1:0] idx_q;
  logic [31:0] data_q;
  // offsets wrap within the line, so the request address never leaves it
  assign req_off = start_q + req_cnt_q[OFF_W-1:0];
  assign resp_off = start_q + resp_cnt_q[OFF_W-1:0];
  assign hs = state_q == ISSUE && MemReqReady;
  assign resp_ok = MemRespValid && (state_q == ISSUE || state_q == DRAIN) && resp_cnt_q != FULL;
  assign MemReqValid = state_q == ISSUE;
  assign MemReqAddr = MemReqValid ? base_q | ADDR_W'({req_off, 2'b00}) : '0;
  assign RefillBusy = state_q == ISSUE || state_q == DRAIN;
  assign RefillDone = state_q == DONE;
  assign WriteInst = wr_q;
  assign CacheIndexWrite = idx_q;
  assign InstData = data_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    start_d = start_q;
    req_cnt_d = req_cnt_q + CNT_W'(hs);
    resp_cnt_d = resp_cnt_q + CNT_W'(resp_ok);
    case (state_q)
      IDLE: if (MissReq) begin
        state_d = ISSUE;
        base_d = MissAddr & ~ADDR_W'(LINE_WORDS * 4 - 1);
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
        start_d = MissAddr[OFF_W+1:2];
`else
        start_d = '0;
`endif
        req_cnt_d = '0;
        resp_cnt_d = '0;
      end
      ISSUE: if (req_cnt_d == FULL) state_d = resp_cnt_q == FULL ? DONE : DRAIN;
      DRAIN: if (resp_cnt_q == FULL) state_d = DONE;
      default: begin
        state_d = IDLE;
        req_cnt_d = '0;
        resp_cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      base_q <= '0;
      start_q <= '0;
      req_cnt_q <= '0;
      resp_cnt_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      start_q <= start_d;
      req_cnt_q <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      wr_q <= resp_ok;
      if (resp_ok) begin
        idx_q <= base_q[INDEX_W+1:2] + INDEX_W'(resp_off);
        data_q <= MemRespData;
      end
    end
  end
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
  logic crit_q;
  always_ff @(posedge clk) crit_q <= Reset ? 1'b0 : resp_ok && resp_cnt_q == '0;
  assign CritWordWritten = crit_q;
`endif
endmodule

// File: tb/tb_inst_cache_refill.sv
// tb_inst_cache_refill: randomized refill scenarios checked against an address-arithmetic line model.
module tb_inst_cache_refill;
  localparam int LINE = 4;
  logic clk = 1'b0;
  logic Reset, MissReq, MemReqReady, MemRespValid;
  logic [31:0] MissAddr, MemRespData, MemReqAddr, InstData;
  logic RefillBusy, RefillDone, MemReqValid, WriteInst;
  logic [6:0] CacheIndexWrite;
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
  logic CritWordWritten;
`endif
  int cyc = 0;
  int n_checks, n_fail;
  logic [31:0] req_addr[$], wr_data[$];
  logic [6:0] wr_idx[$];
  int wr_cyc[$], done_cyc[$], busy_rise[$], crit_cyc[$];
  int unstable, busy_at_done, zero_bad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_cache_refill dut (
    .clk(clk), .Reset(Reset), .MissReq(MissReq), .MissAddr(MissAddr),
    .RefillBusy(RefillBusy), .RefillDone(RefillDone),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqAddr(MemReqAddr),
    .MemRespValid(MemRespValid), .MemRespData(MemRespData),
    .WriteInst(WriteInst), .CacheIndexWrite(CacheIndexWrite),
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
    .CritWordWritten(CritWordWritten),
`endif
    .InstData(InstData)
  );

  function automatic logic [31:0] exp_req(input logic [31:0] miss, input int k);
    int start;
    start = 0;
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
    start = int'((miss >> 2) % 32'(LINE));
`endif
    return (miss & ~32'(LINE * 4 - 1)) + 32'(((start + k) % LINE) * 4);
  endfunction

  function automatic logic [6:0] exp_idx(input logic [31:0] miss, input int k);
    return 7'(exp_req(miss, k) >> 2);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] seed, input logic [31:0] miss, input int k);
    return seed + ((exp_req(miss, k) >> 2) % 32'(LINE));
  endfunction

  // memory side: in-order responses, each at least one cycle after its handshake
  task automatic run(input logic [31:0] a1, input logic [31:0] a2, input bit second, input int rmode,
                     input int maxlat, input logic [31:0] seed, input int abort_after, input bit extra);
    int pend_due[$];
    logic [31:0] pend_addr[$];
    logic [31:0] prev_addr;
    int nresp, nhs, last_due, due, rstcyc, quiet;
    bit prev_wait, prev_busy, extra_next, second_sent;
    req_addr.delete(); wr_data.delete(); wr_idx.delete(); wr_cyc.delete();
    done_cyc.delete(); busy_rise.delete(); crit_cyc.delete();
    unstable = 0; busy_at_done = 0; zero_bad = 0;
    nresp = 0; nhs = 0; last_due = 0; rstcyc = -1; quiet = 0;
    prev_wait = 0; prev_busy = 0; extra_next = 0; second_sent = 0; prev_addr = '0;
    @(negedge clk);
    MissAddr = a1; MissReq = 1'b1; MemRespValid = 1'b0; MemReqReady = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (prev_wait && (!MemReqValid || MemReqAddr !== prev_addr)) unstable++;
      if (WriteInst) begin wr_idx.push_back(CacheIndexWrite); wr_data.push_back(InstData); wr_cyc.push_back(cyc); end
      if (RefillDone) begin done_cyc.push_back(cyc); if (RefillBusy) busy_at_done++; end
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
      if (CritWordWritten) crit_cyc.push_back(cyc);
`endif
      if (RefillBusy && !prev_busy) begin busy_rise.push_back(cyc); MissReq = 1'b0; end
      prev_busy = RefillBusy;
      if (rstcyc >= 0 && cyc == rstcyc + 1) begin
        Reset = 1'b0;
        if (RefillBusy || RefillDone || MemReqValid || WriteInst || MemReqAddr != 0 || CacheIndexWrite != 0 || InstData != 0) zero_bad++;
      end
      MemRespValid = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        MemRespValid = 1'b1;
        MemRespData = seed + ((pend_addr[0] >> 2) % 32'(LINE));
        void'(pend_due.pop_front()); void'(pend_addr.pop_front());
        nresp++;
        if (extra && nresp == LINE) extra_next = 1'b1;
      end else if (extra_next) begin
        MemRespValid = 1'b1; MemRespData = 32'hDEAD_BEEF; extra_next = 1'b0;
      end
      MemReqReady = rmode == 0 ? 1'b1 : rmode == 1 ? (t % 5 == 1 || t % 5 == 4) : 1'($urandom_range(0, 1));
      if (MemReqValid && MemReqReady) begin
        nhs++;
        req_addr.push_back(MemReqAddr);
        due = cyc + $urandom_range(1, maxlat);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_due.push_back(due); pend_addr.push_back(MemReqAddr);
      end
      prev_wait = MemReqValid && !MemReqReady;
      prev_addr = MemReqAddr;
      if (second && !second_sent && nhs == LINE && RefillBusy && !MemReqValid) begin
        MissAddr = a2; MissReq = 1'b1; second_sent = 1'b1;
      end
      if (abort_after > 0 && rstcyc < 0 && wr_idx.size() == abort_after) begin
        Reset = 1'b1; rstcyc = cyc;
        pend_due.push_back(cyc + 2); pend_addr.push_back(a1);
        pend_due.push_back(cyc + 3); pend_addr.push_back(a1);
      end
      if (done_cyc.size() == (second ? 2 : 1) || (rstcyc >= 0 && cyc > rstcyc + 8)) quiet++;
      if (quiet > 3) break;
    end
    MissReq = 1'b0; MemReqReady = 1'b0; MemRespValid = 1'b0; Reset = 1'b0;
  endtask

  task automatic test_reset;
    int wr_seen;
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({RefillBusy, RefillDone, MemReqValid, WriteInst} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {RefillBusy, RefillDone, MemReqValid, WriteInst}); end
    n_checks++; if (MemReqAddr !== 32'h0) begin n_fail++; $display("FAIL reset_reqaddr: got %h expected 0", MemReqAddr); end
    n_checks++; if (CacheIndexWrite !== 7'h0) begin n_fail++; $display("FAIL reset_index: got %h expected 0", CacheIndexWrite); end
    n_checks++; if (InstData !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", InstData); end
    Reset = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      MemRespValid = i < 3; MemRespData = $urandom;
      @(negedge clk);
      if (WriteInst || RefillBusy) wr_seen++;
    end
    MemRespValid = 1'b0;
    n_checks++; if (wr_seen !== 0) begin n_fail++; $display("FAIL idle_resp_ignored: got %0d write/busy cycles expected 0", wr_seen); end
  endtask

  task automatic test_refills;
    logic [31:0] addrs[4] = '{32'h124, 32'h124, 32'h1F8, 32'h3F0};
    int modes[4] = '{0, 1, 0, 2};
    logic [31:0] a, seed;
    for (int i = 0; i < 10; i++) begin
      a = i < 4 ? addrs[i] : $urandom;
      seed = i < 2 ? 32'hA0 : $urandom;
      run(a, 32'h0, 1'b0, i < 4 ? modes[i] : 2, i < 3 ? 1 : 3, seed, 0, i == 0);
      n_checks++; if (req_addr.size() !== LINE) begin n_fail++; $display("FAIL refill%0d_req_count: got %0d expected %0d", i, req_addr.size(), LINE); end
      n_checks++; if (wr_idx.size() !== LINE) begin n_fail++; $display("FAIL refill%0d_write_count: got %0d expected %0d", i, wr_idx.size(), LINE); end
      for (int k = 0; k < LINE; k++) begin
        if (k < req_addr.size()) begin
          n_checks++; if (req_addr[k] !== exp_req(a, k)) begin n_fail++; $display("FAIL refill%0d_req%0d: got %h expected %h", i, k, req_addr[k], exp_req(a, k)); end
        end
        if (k < wr_idx.size()) begin
          n_checks++; if (wr_idx[k] !== exp_idx(a, k)) begin n_fail++; $display("FAIL refill%0d_idx%0d: got %h expected %h", i, k, wr_idx[k], exp_idx(a, k)); end
          n_checks++; if (wr_data[k] !== exp_data(seed, a, k)) begin n_fail++; $display("FAIL refill%0d_data%0d: got %h expected %h", i, k, wr_data[k], exp_data(seed, a, k)); end
        end
      end
      n_checks++; if (done_cyc.size() !== 1) begin n_fail++; $display("FAIL refill%0d_done_count: got %0d expected 1", i, done_cyc.size()); end
      if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
        n_checks++; if (done_cyc[0] !== wr_cyc[wr_cyc.size() - 1] + 1) begin n_fail++; $display("FAIL refill%0d_done_timing: got cycle %0d expected %0d", i, done_cyc[0], wr_cyc[wr_cyc.size() - 1] + 1); end
      end
      n_checks++; if (busy_at_done !== 0) begin n_fail++; $display("FAIL refill%0d_busy_at_done: got %0d expected 0", i, busy_at_done); end
      n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL refill%0d_req_stable: got %0d changes expected 0", i, unstable); end
    end
  endtask

  task automatic test_reset_mid;
    run(32'h124, 32'h0, 1'b0, 0, 1, 32'hA0, 2, 1'b0);
    n_checks++; if (wr_idx.size() !== 2) begin n_fail++; $display("FAIL abort_writes: got %0d expected 2", wr_idx.size()); end
    n_checks++; if (done_cyc.size() !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_cyc.size()); end
    n_checks++; if (zero_bad !== 0) begin n_fail++; $display("FAIL abort_outputs_zero: got %0d nonzero expected 0", zero_bad); end
  endtask

  task automatic test_busy_miss;
    logic [31:0] seed;
    seed = $urandom;
    run(32'h124, 32'h3F0, 1'b1, 0, 3, seed, 0, 1'b0);
    n_checks++; if (req_addr.size() !== 2 * LINE) begin n_fail++; $display("FAIL busy_req_count: got %0d expected %0d", req_addr.size(), 2 * LINE); end
    for (int k = 0; k < LINE && req_addr.size() == 2 * LINE; k++) begin
      n_checks++; if (req_addr[k] !== exp_req(32'h124, k)) begin n_fail++; $display("FAIL busy_first_req%0d: got %h expected %h", k, req_addr[k], exp_req(32'h124, k)); end
      n_checks++; if (req_addr[LINE + k] !== exp_req(32'h3F0, k)) begin n_fail++; $display("FAIL busy_second_req%0d: got %h expected %h", k, req_addr[LINE + k], exp_req(32'h3F0, k)); end
    end
    n_checks++; if (done_cyc.size() !== 2 || busy_rise.size() !== 2) begin n_fail++; $display("FAIL busy_refill_count: got %0d dones %0d starts expected 2 2", done_cyc.size(), busy_rise.size()); end
    if (done_cyc.size() > 0 && busy_rise.size() > 1) begin
      n_checks++; if (busy_rise[1] !== done_cyc[0] + 2) begin n_fail++; $display("FAIL busy_accept_cycle: got %0d expected %0d", busy_rise[1], done_cyc[0] + 2); end
    end
  endtask

`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
  task automatic test_crit;
    logic [31:0] order[4] = '{32'h128, 32'h12C, 32'h120, 32'h124};
    run(32'h128, 32'h0, 1'b0, 0, 1, 32'h55, 0, 1'b0);
    for (int k = 0; k < LINE && k < req_addr.size(); k++) begin
      n_checks++; if (req_addr[k] !== order[k]) begin n_fail++; $display("FAIL crit_req%0d: got %h expected %h", k, req_addr[k], order[k]); end
    end
    n_checks++; if (crit_cyc.size() !== 1) begin n_fail++; $display("FAIL crit_pulse_count: got %0d expected 1", crit_cyc.size()); end
    if (crit_cyc.size() > 0 && wr_cyc.size() > 0) begin
      n_checks++; if (crit_cyc[0] !== wr_cyc[0]) begin n_fail++; $display("FAIL crit_pulse_cycle: got %0d expected %0d", crit_cyc[0], wr_cyc[0]); end
      n_checks++; if (wr_idx[0] !== 7'h4A) begin n_fail++; $display("FAIL crit_first_index: got %h expected 4a", wr_idx[0]); end
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    Reset = 1'b1; MissReq = 1'b0; MissAddr = '0;
    MemReqReady = 1'b0; MemRespValid = 1'b0; MemRespData = '0;
    test_reset;
    test_refills;
    test_reset_mid;
    test_busy_miss;
`ifdef INST_REFILL_CRITICAL_WORD_FIRST_EN
    test_crit;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
